ram_access_ctrl: RTL and testbench

//  Initiator side of the memory_ram port: accepts single load/store requests from the core LSU and drives CE/RD/WR/ADDR/DATA.

---
 rtl/ram_access_ctrl_pkg.sv | 43 ++++
 rtl/ram_access_ctrl_lane_align.sv | 41 ++++
 rtl/ram_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// rtl/ram_access_ctrl_pkg.sv - funct3 codes, FSM encodings and request checks for ram_access_ctrl
package ram_access_ctrl_pkg;

  // RV32I load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller FSM encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_RD_CAP  = 3'd2;
  localparam logic [2:0] ST_RMW_RD  = 3'd3;
  localparam logic [2:0] ST_RMW_MRG = 3'd4;
  localparam logic [2:0] ST_WR      = 3'd5;
  localparam logic [2:0] ST_RESP    = 3'd6;
  localparam logic [2:0] ST_ERR     = 3'd7;

  // Unsigned widths exist only for loads; the three unused codes are always illegal
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Halves need even addresses, words need word-aligned addresses
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_lane_align.sv
// rtl/ram_access_ctrl_lane_align.sv - sub-word lane extract/extend for loads and lane merge for stores
module ram_access_ctrl_lane_align
  import ram_access_ctrl_pkg::*;
(
  input  logic [31:0] ram_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [31:0] shifted;
  logic [15:0] half;

  // Load path: pick the little-endian lane and sign/zero extend it
  always_comb begin
    shifted = ram_word >> {byte_off, 3'b000};
    half    = byte_off[1] ? ram_word[31:16] : ram_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{half[15]}}, half};
      F3_HU:   load_data = {16'h0, half};
      default: load_data = ram_word;
    endcase
  end

  // Store path: overwrite only the addressed lane of the old word
  always_comb begin
    merged_word = ram_word;
    case (funct3)
      F3_B:    merged_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merged_word = byte_off[1] ? {wdata[15:0], ram_word[15:0]}
                                         : {ram_word[31:16], wdata[15:0]};
      F3_W:    merged_word = wdata;
      default: merged_word = ram_word;
    endcase
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - single-outstanding LSU-to-RAM controller with sub-word read-modify-write
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iREQ_VALID,
  output logic              oREQ_READY,
  input  logic              iREQ_WE,
  input  logic [2:0]        iREQ_FUNCT3,
  input  logic [31:0]       iREQ_ADDR,
  input  logic [31:0]       iREQ_WDATA,
  output logic              oRSP_VALID,
  output logic [31:0]       oRSP_RDATA,
  output logic              oRSP_ERR,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [31:0]       oRAM_DATA,
  input  logic [31:0]       iRAM_DATA
);

  logic [2:0]        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ce_q, ce_d, rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_data_q, ram_data_d;

  logic              accept;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;

  assign accept  = iREQ_VALID && (state_q == ST_IDLE);
  assign req_err = f3_illegal(iREQ_WE, iREQ_FUNCT3)
                 | f3_misaligned(iREQ_FUNCT3, iREQ_ADDR[1:0])
                 | (|iREQ_ADDR[31:ADDR_W+2]);

  ram_access_ctrl_lane_align u_lane_align (
    .ram_word    (iRAM_DATA),
    .wdata       (wdata_q),
    .byte_off    (off_q),
    .funct3      (f3_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Next-state logic; strobes are computed for the state being entered so they come straight from flops
  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ce_d       = 1'b0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          f3_d    = iREQ_FUNCT3;
          off_d   = iREQ_ADDR[1:0];
          wdata_d = iREQ_WDATA;
          rdata_d = 32'h0;
          if (req_err) begin
            state_d = ST_ERR;
          end else begin
            ram_addr_d = iREQ_ADDR[ADDR_W+1:2];
            ce_d       = 1'b1;
            if (!iREQ_WE) begin
              state_d = ST_RD;
              rd_d    = 1'b1;
            end else if (iREQ_FUNCT3 == F3_W) begin
              state_d    = ST_WR;
              wr_d       = 1'b1;
              ram_data_d = iREQ_WDATA;
            end else begin
              state_d = ST_RMW_RD;
              rd_d    = 1'b1;
            end
          end
        end
      end
      ST_RD:     state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_RMW_RD: state_d = ST_RMW_MRG;
      ST_RMW_MRG: begin
        ram_data_d = merged_word;
        ce_d       = 1'b1;
        wr_d       = 1'b1;
        state_d    = ST_WR;
      end
      ST_WR:     state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, request and RAM-port registers; reset drops strobes immediately and abandons any access
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= ST_IDLE;
      f3_q       <= 3'h0;
      off_q      <= 2'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      ce_q       <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ce_q       <= ce_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign oREQ_READY = (state_q == ST_IDLE);
  assign oRSP_VALID = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign oRSP_ERR   = (state_q == ST_ERR);
  assign oRSP_RDATA = rdata_q;
  assign oRAM_CE    = ce_q;
  assign oRAM_RD    = rd_q;
  assign oRAM_WR    = wr_q;
  assign oRAM_ADDR  = ram_addr_q;
  assign oRAM_DATA  = ram_data_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - scoreboard bench for ram_access_ctrl with a word RAM model
`timescale 1ns/1ps
module tb_ram_access_ctrl;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_f3 = 3'b0;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              ram_ce, ram_rd, ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  bit [31:0] mem [256];
  bit [31:0] ram_q;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  int   wr_cnt = 0;
  int   strobe_viol = 0;
  int   acc_cnt = 0;

  always #5 clk = ~clk;

  ram_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iREQ_VALID  (req_valid),
    .oREQ_READY  (req_ready),
    .iREQ_WE     (req_we),
    .iREQ_FUNCT3 (req_f3),
    .iREQ_ADDR   (req_addr),
    .iREQ_WDATA  (req_wdata),
    .oRSP_VALID  (rsp_valid),
    .oRSP_RDATA  (rsp_rdata),
    .oRSP_ERR    (rsp_err),
    .oRAM_CE     (ram_ce),
    .oRAM_RD     (ram_rd),
    .oRAM_WR     (ram_wr),
    .oRAM_ADDR   (ram_addr),
    .oRAM_DATA   (ram_wdata),
    .iRAM_DATA   (ram_rdata)
  );

  // Word-only synchronous RAM: read data appears the cycle after CE&RD
  always @(posedge clk) begin
    if (ram_ce && ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_ce && ram_rd) ram_q <= mem[ram_addr];
  end
  assign ram_rdata = ram_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: strobe sanity, write counting and scoreboard pop on every response
  always @(negedge clk) begin
    if ((ram_rd && ram_wr) || (!ram_ce && (ram_rd || ram_wr))) strobe_viol++;
    if (ram_wr) wr_cnt++;
    if (rst_n && rsp_valid) begin
      rsp_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input bit hold);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cnt++;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    e.acc   = cyc;
    sb_q.push_back(e);
    if (!hold) begin
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = $urandom;
      req_f3    = 3'b111;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 32'd0);
  endtask

  initial begin
    int wr_snap;
    int rsp_snap;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_strobes", {29'b0, ram_ce, ram_rd, ram_wr}, 32'd0);
    chk("rst_ram_data", ram_wdata, 32'd0);
    chk("rst_ram_addr", {24'b0, ram_addr}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;

    // 1: word store and load
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0);
    do_req(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0);

    // 2: byte store and signed/unsigned byte loads
    do_req(1, 3'b000, 32'h11, 32'h12345680, 32'h0, 0, 4, 0);
    do_req(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 0, 3, 0);
    do_req(0, 3'b100, 32'h11, 32'h0, 32'h00000080, 0, 3, 0);
    do_req(0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0, 3, 0);

    // 3: half store and half loads
    do_req(1, 3'b001, 32'h12, 32'hABCD1234, 32'h0, 0, 4, 0);
    do_req(0, 3'b001, 32'h12, 32'h0, 32'h00001234, 0, 3, 0);
    do_req(0, 3'b101, 32'h10, 32'h0, 32'h000080EF, 0, 3, 0);
    do_req(0, 3'b001, 32'h10, 32'h0, 32'hFFFF80EF, 0, 3, 0);
    do_req(0, 3'b000, 32'h13, 32'h0, 32'h00000012, 0, 3, 0);
    do_req(0, 3'b010, 32'h10, 32'h0, 32'h123480EF, 0, 3, 0);
    drain();

    // 4: error responses, no RAM write
    wr_snap = wr_cnt;
    do_req(0, 3'b010, 32'h13, 32'h0, 32'h0, 1, 1, 0);
    do_req(1, 3'b001, 32'h11, 32'h5555, 32'h0, 1, 1, 0);
    do_req(1, 3'b010, 32'h400, 32'h11111111, 32'h0, 1, 1, 0);
    do_req(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 0);
    do_req(1, 3'b100, 32'h10, 32'h77, 32'h0, 1, 1, 0);
    drain();
    chk("err_no_write", wr_cnt - wr_snap, 32'd0);
    do_req(0, 3'b010, 32'h10, 32'h0, 32'h123480EF, 0, 3, 0);
    drain();

    // 5: reset during the write phase of a byte store
    rsp_snap = rsp_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_f3    = 3'b000;
    req_addr  = 32'h20;
    req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ram_wr && n < 20);
    chk("rmw_reached_wr", {31'b0, ram_wr}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_strobes_async", {29'b0, ram_ce, ram_rd, ram_wr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("no_rsp_after_rst", rsp_cnt - rsp_snap, 32'd0);
    do_req(0, 3'b010, 32'h20, 32'h0, 32'h00000000, 0, 3, 0);
    drain();

    // 6: valid held high across ten mixed requests
    rsp_snap = rsp_cnt;
    acc_cnt  = 0;
    do_req(1, 3'b010, 32'h24, 32'hCAFEF00D, 32'h0, 0, 2, 1);
    do_req(0, 3'b010, 32'h24, 32'h0, 32'hCAFEF00D, 0, 3, 1);
    do_req(1, 3'b000, 32'h27, 32'h7F, 32'h0, 0, 4, 1);
    do_req(0, 3'b000, 32'h27, 32'h0, 32'h0000007F, 0, 3, 1);
    do_req(0, 3'b101, 32'h26, 32'h0, 32'h00007FFE, 0, 3, 1);
    do_req(0, 3'b001, 32'h24, 32'h0, 32'hFFFFF00D, 0, 3, 1);
    do_req(0, 3'b010, 32'h26, 32'h0, 32'h0, 1, 1, 1);
    do_req(1, 3'b001, 32'h24, 32'hBEEF, 32'h0, 0, 4, 1);
    do_req(0, 3'b100, 32'h24, 32'h0, 32'h000000EF, 0, 3, 1);
    do_req(0, 3'b010, 32'h24, 32'h0, 32'h7FFEBEEF, 0, 3, 0);
    drain();
    repeat (3) @(negedge clk);
    chk("b2b_accepts", acc_cnt, 32'd10);
    chk("b2b_responses", rsp_cnt - rsp_snap, 32'd10);
    chk("strobe_exclusive", strobe_viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
